// File: rtl/cpu_core_pkg.sv
// -----------------------------------------------------------------------------
// cpu_core_pkg
// Shared definitions for the Evergreen multicycle CPU:
//   - opcode encodings (OP_MOV .. OP_STOP)
//   - FSM state encoding
//   - reset constants for pc and sp
//   - decode helpers that classify an opcode by the operands it touches
// Configuration macro: CPU_MULDIV_EN (enables MUL/DIV; otherwise they decode
// as NOPs).
// -----------------------------------------------------------------------------
package cpu_core_pkg;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_PUSH = 4'h9;
  localparam logic [3:0] OP_POP  = 4'hA;
  localparam logic [3:0] OP_STOP = 4'hF;

  localparam int PC_RESET = 8;
  localparam int SP_RESET = 63;

`ifdef CPU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    RD_Y,
    RD_Y_IND,
    RD_Z,
    RD_Z_IND,
    RD_X_IND,
    EXEC,
    WB,
    HALT
  } state_t;

  // MUL/DIV only count as real instructions when the multiplier/divider exists
  function automatic logic isMulDiv(input logic [3:0] op);
    return MULDIV_EN && (op == OP_MUL || op == OP_DIV);
  endfunction

  // Instructions that read a first source operand (Y, or X for OUT/PUSH, or
  // the stack slot for POP)
  function automatic logic usesA(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_PUSH) || (op == OP_POP) || isMulDiv(op);
  endfunction

  // Instructions that read the Z operand
  function automatic logic usesB(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || isMulDiv(op);
  endfunction

  // Instructions whose destination is the X operand
  function automatic logic writesX(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_IN) || (op == OP_POP) || isMulDiv(op);
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu
// Combinational ALU for the Evergreen CPU.
// Ports:
//   op_i      opcode of the current instruction
//   a_i       first source operand (Y)
//   b_i       second source operand (Z)
//   result_o  operation result, truncated to DATA_WIDTH
// Configuration macro: CPU_MULDIV_EN adds the multiplier and unsigned divider.
// Any opcode without an arithmetic meaning passes a_i through, which is what
// MOV, PUSH and POP need.
// -----------------------------------------------------------------------------
module cpu_alu
  import cpu_core_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  always_comb begin
    result_o = a_i;
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
`ifdef CPU_MULDIV_EN
      OP_MUL: result_o = a_i * b_i;
      // Divide by zero saturates to all-ones instead of trapping
      OP_DIV: result_o = (b_i == '0) ? '1 : a_i / b_i;
`else
`endif
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// -----------------------------------------------------------------------------
// cpu_core
// Multicycle 16-bit memory-to-memory CPU (Evergreen ISA) driving a single
// synchronous RAM whose read data appears one clock after the address.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in        input port value, captured by IN
//   out       output register, written by OUT
//   mem_we    RAM write enable (write-back of a result or a PUSH)
//   mem_addr  RAM address (driven during the address phase of a read, or WB)
//   mem_data  RAM write data
//   mem_in    RAM read data
//   pc        program counter
//   sp        stack pointer
// Configuration macro: CPU_MULDIV_EN (MUL/DIV execute; otherwise opcodes 3/4
// are NOPs and no multiplier/divider exists).
// Every read takes two cycles: phase 0 presents the address, phase 1 latches
// mem_in. Indirect operands chain a second read through the fetched pointer.
// -----------------------------------------------------------------------------
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp
);

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] opA_q, opA_d;
  logic [DATA_WIDTH-1:0] opB_q, opB_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;

  logic [3:0]            opcode;
  logic [3:0]            nibX, nibY, nibZ, nibA;
  logic                  dstInd;
  state_t                afterA, afterB;
  logic [DATA_WIDTH-1:0] aluResult;

  // Operand nibble bits 2:0 name one of the first eight memory words
  function automatic logic [ADDR_WIDTH-1:0] nibAddr(input logic [3:0] nib);
    return {{(ADDR_WIDTH-3){1'b0}}, nib[2:0]};
  endfunction

  assign opcode = instr_q[15:12];
  assign nibX   = instr_q[11:8];
  assign nibY   = instr_q[7:4];
  assign nibZ   = instr_q[3:0];

  // OUT and PUSH read their X operand through the same path as Y
  assign nibA   = (opcode == OP_OUT || opcode == OP_PUSH) ? nibX : nibY;
  assign dstInd = writesX(opcode) && nibX[3];
  assign afterB = dstInd ? RD_X_IND : EXEC;
  assign afterA = usesB(opcode) ? RD_Z : afterB;

  cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op_i     (opcode),
    .a_i      (opA_q),
    .b_i      (opB_q),
    .result_o (aluResult)
  );

  // State and datapath registers; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      phase_q  <= 1'b0;
      pc_q     <= ADDR_WIDTH'(PC_RESET);
      sp_q     <= ADDR_WIDTH'(SP_RESET);
      instr_q  <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      result_q <= '0;
      dst_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      instr_q  <= instr_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      result_q <= result_d;
      dst_q    <= dst_d;
      out_q    <= out_d;
    end
  end

  // Next-state, datapath updates and memory interface
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    instr_d  = instr_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    result_d = result_q;
    dst_d    = dst_q;
    out_d    = out_q;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;

    case (state_q)
      FETCH: begin
        if (!phase_q) begin
          mem_addr = pc_q;
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          instr_d = mem_in;
          pc_d    = pc_q + 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        // PUSH writes to the current stack slot; POP pre-increments so that
        // the operand read below uses the new sp
        dst_d = (opcode == OP_PUSH) ? sp_q : nibAddr(nibX);
        if (opcode == OP_POP) sp_d = sp_q + 1'b1;
        if (opcode == OP_STOP)      state_d = HALT;
        else if (usesA(opcode))     state_d = RD_Y;
        else if (opcode == OP_IN)   state_d = nibX[3] ? RD_X_IND : EXEC;
        else                        state_d = FETCH;
      end

      RD_Y: begin
        if (!phase_q) begin
          mem_addr = (opcode == OP_POP) ? sp_q : nibAddr(nibA);
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          opA_d   = mem_in;
          state_d = (opcode != OP_POP && nibA[3]) ? RD_Y_IND : afterA;
        end
      end

      RD_Y_IND: begin
        if (!phase_q) begin
          mem_addr = opA_q[ADDR_WIDTH-1:0];
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          opA_d   = mem_in;
          state_d = afterA;
        end
      end

      RD_Z: begin
        if (!phase_q) begin
          mem_addr = nibAddr(nibZ);
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          opB_d   = mem_in;
          state_d = nibZ[3] ? RD_Z_IND : afterB;
        end
      end

      RD_Z_IND: begin
        if (!phase_q) begin
          mem_addr = opB_q[ADDR_WIDTH-1:0];
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          opB_d   = mem_in;
          state_d = afterB;
        end
      end

      RD_X_IND: begin
        // Indirect destination: the pointer word becomes the write address
        if (!phase_q) begin
          mem_addr = nibAddr(nibX);
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          dst_d   = mem_in[ADDR_WIDTH-1:0];
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (opcode == OP_OUT) begin
          out_d   = opA_q;
          state_d = FETCH;
        end else begin
          result_d = (opcode == OP_IN) ? in : aluResult;
          state_d  = WB;
        end
      end

      WB: begin
        mem_we   = 1'b1;
        mem_addr = dst_q;
        mem_data = result_q;
        if (opcode == OP_PUSH) sp_d = sp_q - 1'b1;
        state_d = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
        phase_d = 1'b0;
      end
    endcase
  end

  assign out = out_q;
  assign pc  = pc_q;
  assign sp  = sp_q;

endmodule

// File: tb/tb_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_cpu_core
// Directed programs for the Evergreen CPU. Each program's expected memory
// writes are queued before it runs; a monitor pops one entry per write the
// CPU performs and compares address, data and (where given) the cycle count
// since reset release. Register-style outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_cpu_core;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] inPort = '0;
  logic [DW-1:0] outPort;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic [DW-1:0] memIn;
  logic [AW-1:0] pcOut;
  logic [AW-1:0] spOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_core #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (inPort),
    .out      (outPort),
    .mem_we   (memWe),
    .mem_addr (memAddr),
    .mem_data (memData),
    .mem_in   (memIn),
    .pc       (pcOut),
    .sp       (spOut)
  );

  // Synchronous RAM model; the bench preloads it through the load port while
  // the CPU is held in reset
  logic [DW-1:0] ram [64];
  logic          loadEn = 1'b0;
  logic [AW-1:0] loadAddr = '0;
  logic [DW-1:0] loadData = '0;

  always @(posedge clk) begin
    if (loadEn) ram[loadAddr] <= loadData;
    else if (memWe) ram[memAddr] <= memData;
    memIn <= ram[memAddr];
  end

  // Clock edges since the last reset release, used to pin write timing
  int cycleCnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycleCnt <= 0;
    else cycleCnt <= cycleCnt + 1;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } init_t;

  wr_t   expQ[$];
  init_t initQ[$];
  wr_t   monEntry;

  // Monitor: every CPU write must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && memWe) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%h, no write expected", memAddr, memData);
      end else begin
        monEntry = expQ.pop_front();
        if (memAddr !== monEntry.addr || memData !== monEntry.data ||
            (monEntry.cyc >= 0 && cycleCnt != monEntry.cyc)) begin
          errors++;
          $display("[TB] FAIL mem_write: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                   memAddr, memData, cycleCnt, monEntry.addr, monEntry.data, monEntry.cyc);
        end
      end
    end
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Every queued write must have been consumed by the monitor
  task automatic checkQueueEmpty(input string name);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d writes missing, expected 0", name, expQ.size());
    end
    expQ.delete();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    init_t e;
    e.addr = a;
    e.data = d;
    initQ.push_back(e);
  endtask

  task automatic expectWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input int cyc);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc;
    expQ.push_back(e);
  endtask

  // Hold reset, clear RAM, load the queued image, then release reset
  task automatic applyStimulus();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      loadEn   = 1'b1;
      loadAddr = AW'(i);
      loadData = '0;
    end
    foreach (initQ[i]) begin
      @(negedge clk);
      loadAddr = initQ[i].addr;
      loadData = initQ[i].data;
    end
    initQ.delete();
    @(negedge clk);
    loadEn = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    $display("[TB] reset hold");
    repeat (3) @(negedge clk);
    checkOutput("reset_pc", 32'(pcOut), 32'd8);
    checkOutput("reset_sp", 32'(spOut), 32'd63);
    checkOutput("reset_out", 32'(outPort), 32'd0);
    checkOutput("reset_we", 32'(memWe), 32'd0);
    waitCycles(4);
    checkOutput("reset_hold_pc", 32'(pcOut), 32'd8);
    checkOutput("reset_hold_sp", 32'(spOut), 32'd63);

    $display("[TB] direct ADD");
    preload(8, 16'h1123);
    preload(9, 16'hF000);
    preload(2, 16'd5);
    preload(3, 16'd7);
    expectWrite(1, 16'd12, 8);
    applyStimulus();
    waitCycles(8);
    checkOutput("add_pc_at_wb", 32'(pcOut), 32'd9);
    waitCycles(12);
    checkOutput("add_pc_halt", 32'(pcOut), 32'd10);
    checkQueueEmpty("add_writes");

    $display("[TB] reset mid-instruction");
    preload(8, 16'h1123);
    preload(2, 16'd5);
    preload(3, 16'd7);
    applyStimulus();
    waitCycles(5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_pc", 32'(pcOut), 32'd8);
    checkOutput("midrst_sp", 32'(spOut), 32'd63);
    checkOutput("midrst_we", 32'(memWe), 32'd0);
    waitCycles(4);
    checkQueueEmpty("midrst_writes");

    $display("[TB] indirect MOV");
    preload(8, 16'h09A0);
    preload(9, 16'hF000);
    preload(1, 16'd1);
    preload(2, 16'd4);
    preload(4, 16'hBEEF);
    expectWrite(1, 16'hBEEF, 10);
    applyStimulus();
    waitCycles(25);
    checkOutput("mov_pc_halt", 32'(pcOut), 32'd10);
    checkQueueEmpty("mov_writes");

    $display("[TB] IN/OUT/STOP");
    inPort = 16'h01A5;
    preload(8, 16'h7100);
    preload(9, 16'h8100);
    preload(10, 16'hF000);
    expectWrite(1, 16'h01A5, 4);
    applyStimulus();
    waitCycles(30);
    checkOutput("io_out", 32'(outPort), 32'h01A5);
    checkOutput("io_pc_halt", 32'(pcOut), 32'd11);
    waitCycles(6);
    checkOutput("io_pc_frozen", 32'(pcOut), 32'd11);
    checkQueueEmpty("io_writes");

    $display("[TB] PUSH/POP");
    inPort = '0;
    preload(8, 16'h9100);
    preload(9, 16'hA200);
    preload(10, 16'hF000);
    preload(1, 16'd3);
    expectWrite(63, 16'd3, 6);
    expectWrite(2, 16'd3, 13);
    applyStimulus();
    checkOutput("out_cleared_by_reset", 32'(outPort), 32'd0);
    waitCycles(7);
    checkOutput("push_sp", 32'(spOut), 32'd62);
    waitCycles(20);
    checkOutput("pop_sp", 32'(spOut), 32'd63);
    checkQueueEmpty("pushpop_writes");

    $display("[TB] sp wrap");
    preload(8, 16'hA200);
    preload(9, 16'h9200);
    preload(10, 16'hF000);
    preload(0, 16'h1234);
    expectWrite(2, 16'h1234, 6);
    expectWrite(0, 16'h1234, 13);
    applyStimulus();
    waitCycles(7);
    checkOutput("pop_wrap_sp", 32'(spOut), 32'd0);
    waitCycles(20);
    checkOutput("push_wrap_sp", 32'(spOut), 32'd63);
    checkQueueEmpty("wrap_writes");

    $display("[TB] DIV/MUL/SUB/NOP");
    preload(8, 16'h4123);
    preload(9, 16'h3524);
    preload(10, 16'h2632);
    preload(11, 16'h5000);
    preload(12, 16'hF000);
    preload(2, 16'd9);
    preload(3, 16'd0);
    preload(4, 16'd7);
`ifdef CPU_MULDIV_EN
    expectWrite(1, 16'hFFFF, -1);
    expectWrite(5, 16'h003F, -1);
`endif
    expectWrite(6, 16'hFFF7, -1);
    applyStimulus();
    waitCycles(70);
    checkOutput("arith_pc_halt", 32'(pcOut), 32'd13);
    checkQueueEmpty("arith_writes");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
